// File: rtl/wca_cic_interp_n.sv
// N-stage, multi-channel CIC interpolator. Low-rate samples arrive on a
// valid/ready stream into a single holding register. They are consumed on
// every R-th high-rate strobe, zero-stuffed in between, and scaled back to
// unity DC gain with half-up rounding and saturation.

// One channel: comb chain, integrator cascade, scaling and the output register.
module wca_cic_interp_n_lane #(
    parameter int DW    = 16,
    parameter int N     = 3,
    parameter int ACC_W = 40
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_strobe,
    input  logic                 i_phase0,
    input  logic signed [DW-1:0] i_x,
    input  logic [7:0]           i_shift,
    output logic signed [DW-1:0] o_y
);
    localparam logic [ACC_W:0]        ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+1-DW){1'b0}}, 1'b0, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] r_dly   [1:N];
    logic signed [ACC_W-1:0] r_integ [1:N];
    logic signed [ACC_W-1:0] w_cin   [1:N];
    logic signed [ACC_W-1:0] w_comb;
    logic signed [ACC_W:0]   w_ext;
    logic [ACC_W:0]          w_rnd;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_sh;
    logic signed [DW-1:0]    w_sat;
    logic signed [DW-1:0]    r_y;

    // Comb chain evaluated against the stored delays; w_cin[k] is what stage k's delay will take.
    always_comb begin : comb_chain
        logic signed [ACC_W-1:0] v;
        v = {{(ACC_W-DW){i_x[DW-1]}}, i_x};
        for (int k = 1; k <= N; k++) begin
            w_cin[k] = v;
            v        = v - r_dly[k];
        end
        w_comb = v;
    end

    // Gain normalisation: one guard bit so the rounding add cannot wrap, then shift and clip.
    always_comb begin
        w_ext = {r_integ[N][ACC_W-1], r_integ[N]};
        w_rnd = (i_shift != 8'd0) ? (ONE << (i_shift - 8'd1)) : '0;
        w_sum = w_ext + $signed(w_rnd);
        w_sh  = w_sum >>> i_shift;
        if (w_sh > MAXV)      w_sat = MAXV[DW-1:0];
        else if (w_sh < MINV) w_sat = MINV[DW-1:0];
        else                  w_sat = w_sh[DW-1:0];
    end

    // Per-strobe state update: delays on phase 0 only, integrators cascade from pre-update values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 1; k <= N; k++) begin
                r_dly[k]   <= '0;
                r_integ[k] <= '0;
            end
            r_y <= '0;
        end else if (i_clear) begin
            for (int k = 1; k <= N; k++) begin
                r_dly[k]   <= '0;
                r_integ[k] <= '0;
            end
            r_y <= '0;
        end else if (i_strobe) begin
            if (i_phase0) begin
                for (int k = 1; k <= N; k++) r_dly[k] <= w_cin[k];
            end
            r_integ[1] <= r_integ[1] + (i_phase0 ? w_comb : '0);
            for (int k = 2; k <= N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
            r_y <= w_sat;
        end
    end

    assign o_y = r_y;
endmodule

module wca_cic_interp_n #(
    parameter int DW       = 16,
    parameter int N        = 3,
    parameter int CH       = 2,
    parameter int MAX_LOG2 = 8,
    parameter int ACC_W    = DW + N * MAX_LOG2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_strobe_if,
    input  logic [3:0]       i_log2_rate,
    input  logic [CH*DW-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [CH*DW-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_underrun
);
    localparam int         PW   = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam logic [3:0] RMAX = 4'(MAX_LOG2);

    logic             r_latched;
    logic [3:0]       r_rate_q;
    logic [PW-1:0]    r_phase;
    logic [CH*DW-1:0] r_hold;
    logic             r_full;
    logic             r_underrun;
    logic             r_out_valid;

    logic [3:0]       w_rate_in;
    logic [PW:0]      w_rlen;
    logic [PW:0]      w_last;
    logic             w_strobe;
    logic             w_phase0;
    logic             w_consume;
    logic             w_load;
    logic [7:0]       w_shift;

    assign w_rate_in  = (i_log2_rate > RMAX) ? RMAX : i_log2_rate;
    assign w_rlen     = {{PW{1'b0}}, 1'b1} << r_rate_q;
    assign w_last     = w_rlen - {{PW{1'b0}}, 1'b1};
    // Strobes are ignored until the rate has been latched (first enabled cycle).
    assign w_strobe   = i_strobe_if & i_enable & r_latched;
    assign w_phase0   = (r_phase == '0);
    assign w_consume  = w_strobe & w_phase0;
    assign o_in_ready = i_enable & r_latched & ~r_full;
    assign w_load     = i_in_valid & o_in_ready;
    assign w_shift    = 8'(N - 1) * {4'd0, r_rate_q};

    // Control: rate latch, holding register, phase counter, sticky underrun, output strobe.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_latched   <= 1'b0;
            r_rate_q    <= '0;
            r_phase     <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_underrun  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!i_enable) begin
            r_latched   <= 1'b0;
            r_rate_q    <= '0;
            r_phase     <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_underrun  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!r_latched) begin
            r_latched   <= 1'b1;
            r_rate_q    <= w_rate_in;
            r_out_valid <= 1'b0;
        end else begin
            // Load only happens when empty, so load wins over a same-cycle consume.
            if (w_load) begin
                r_hold <= i_in_data;
                r_full <= 1'b1;
            end else if (w_consume) begin
                r_full <= 1'b0;
            end
            if (w_consume && !r_full) r_underrun <= 1'b1;
            if (w_strobe) r_phase <= (r_phase == w_last[PW-1:0]) ? '0 : r_phase + PW'(1);
            r_out_valid <= w_strobe;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic signed [DW-1:0] w_x;
        logic signed [DW-1:0] w_y;
        assign w_x = r_full ? r_hold[c*DW +: DW] : '0;
        wca_cic_interp_n_lane #(.DW(DW), .N(N), .ACC_W(ACC_W)) u_lane (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_clear  (~i_enable),
            .i_strobe (w_strobe),
            .i_phase0 (w_phase0),
            .i_x      (w_x),
            .i_shift  (w_shift),
            .o_y      (w_y)
        );
        assign o_out_data[c*DW +: DW] = w_y;
    end

    assign o_out_valid = r_out_valid;
    assign o_underrun  = r_underrun;
endmodule

// File: tb/tb_wca_cic_interp_n.sv
// Directed bench for wca_cic_interp_n (DW=16, N=3, CH=2) with hand-computed expectations.
module tb_wca_cic_interp_n;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        strobe;
    logic [3:0]  log2_rate;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    // 1024-amplitude and unit-amplitude impulse responses at R=4, output from strobe k+3.
    int h1024 [10] = '{64, 192, 384, 640, 768, 768, 640, 384, 192, 64};
    int h1    [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};

    always #5 clk = ~clk;

    wca_cic_interp_n dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_strobe_if (strobe),
        .i_log2_rate (log2_rate),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_underrun  (underrun)
    );

    function automatic int ch0();
        logic signed [15:0] v;
        v = out_data[15:0];
        return int'(v);
    endfunction

    function automatic int ch1();
        logic signed [15:0] v;
        v = out_data[31:16];
        return int'(v);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one sample; waits (bounded) for in_ready, then presents it for exactly one edge.
    task automatic push(input logic [15:0] d0, input logic [15:0] d1);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL push_timeout: observed=in_ready low required=in_ready high");
        end
        in_valid = 1'b1;
        in_data  = {d1, d0};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One-cycle strobe; returns at the following negedge where the registered outputs are visible.
    task automatic do_strobe();
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic restart(input logic [3:0] rate);
        @(negedge clk);
        enable    = 1'b0;
        log2_rate = rate;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    // Impulse on ch0 at R=4 with zeros fed on every later phase-0 strobe.
    task automatic run_imp(input int amp, input bit big);
        int e;
        for (int s = 0; s < 16; s++) begin
            if (s % 4 == 0) push((s == 0) ? 16'(amp) : 16'd0, 16'd0);
            do_strobe();
            e = 0;
            if (s >= 3 && s < 13) e = big ? h1024[s-3] : h1[s-3];
            check(big ? "imp1024_ch0" : "imp1_ch0", ch0(), e);
            check("imp_ch1", ch1(), 0);
            check("imp_out_valid", int'(out_valid), 1);
        end
        @(negedge clk);
        check("imp_out_valid_drop", int'(out_valid), 0);
        check("imp_underrun", int'(underrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        strobe    = 1'b0;
        log2_rate = 4'd2;
        in_data   = '0;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        rst = 1'b0;

        // Impulses at R=4: exact scaling, then half-up rounding of small values.
        restart(4'd2);
        run_imp(1024, 1'b1);
        restart(4'd2);
        run_imp(1, 1'b0);

        // Constant input: unity DC gain, including the negative full-scale code.
        restart(4'd2);
        for (int s = 0; s < 24; s++) begin
            if (s % 4 == 0) push(16'd1000, 16'h8000);
            do_strobe();
            if (s >= 12) begin
                check("dc_ch0", ch0(), 1000);
                check("dc_ch1", ch1(), -32768);
            end
        end
        check("dc_underrun", int'(underrun), 0);

        // R=1: every strobe is phase 0 and the filter is a pure N-strobe delay.
        restart(4'd0);
        for (int s = 0; s < 8; s++) begin
            push(16'(100 * (s + 1)), 16'(-100 * (s + 1)));
            do_strobe();
            if (s >= 3) begin
                check("r1_ch0", ch0(), 100 * (s - 2));
                check("r1_ch1", ch1(), -100 * (s - 2));
            end
        end

        // Starvation: underrun on the first empty phase-0 strobe, sticky, output decays.
        restart(4'd2);
        push(16'd500, 16'd0);
        for (int s = 0; s <= 16; s++) begin
            do_strobe();
            if (s == 3) begin
                check("ur_before", int'(underrun), 0);
                check("ur_ch0_s3", ch0(), 31);
            end
            if (s == 4) check("ur_set", int'(underrun), 1);
            if (s == 16) begin
                check("ur_sticky", int'(underrun), 1);
                check("ur_decay", ch0(), 0);
            end
        end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_underrun", int'(underrun), 0);
        check("dis_out_data", int'(out_data), 0);
        check("dis_in_ready", int'(in_ready), 0);

        // Rate change while enabled is ignored until enable toggles.
        restart(4'd2);
        log2_rate = 4'd3;
        push(16'd0, 16'd0);
        for (int s = 0; s < 8; s++) begin
            do_strobe();
            check("cad4_ready", int'(in_ready), (s % 4 == 0) ? 1 : 0);
            if (in_ready) push(16'd0, 16'd0);
        end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        push(16'd0, 16'd0);
        for (int s = 0; s < 16; s++) begin
            do_strobe();
            check("cad8_ready", int'(in_ready), (s % 8 == 0) ? 1 : 0);
            if (in_ready) push(16'd0, 16'd0);
        end

        // Asynchronous reset mid-impulse, then the impulse must reproduce exactly.
        restart(4'd2);
        push(16'd1024, 16'd0);
        for (int s = 0; s <= 6; s++) begin
            if (s == 4) push(16'd0, 16'd0);
            do_strobe();
        end
        check("ar_pre_ch0", ch0(), 640);
        check("ar_pre_ready", int'(in_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_data", int'(out_data), 0);
        check("ar_in_ready", int'(in_ready), 0);
        check("ar_underrun", int'(underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        run_imp(1024, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
